// File: rtl/mistral_dsp_pkg.sv
// mistral_dsp_pkg: partial-sum FSM states and saturation limits shared by the MAC accumulator.
package mistral_dsp_pkg;
  localparam int MAX_ACC_W = 96;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  typedef enum logic {IDLE, ACCUM} state_e;
  function automatic logic [MAX_ACC_W-1:0] acc_max(input int w);
    return (MAX_ACC_W'(1) << (w - 1)) - MAX_ACC_W'(1);
  endfunction
  function automatic logic [MAX_ACC_W-1:0] acc_min(input int w);
    return MAX_ACC_W'(1) << (w - 1);
  endfunction
endpackage

// File: rtl/mistral_sat_add.sv
// mistral_sat_add: signed adder with overflow flag and optional clamp to the signed range.
module mistral_sat_add
  import mistral_dsp_pkg::*;
#(
  parameter int W   = 64,
  parameter bit SAT = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W-1:0] raw;
  always_comb begin
    raw = a + b;
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum = (SAT && ovf) ? (a[W-1] ? W'(acc_min(W)) : W'(acc_max(W))) : raw;
  end
endmodule

// File: rtl/mistral_mac_accum.sv
// mistral_mac_accum: groups signed products into sums, one registered result per P_LAST beat.
module mistral_mac_accum
  import mistral_dsp_pkg::*;
#(
  parameter int P_WIDTH   = 54,
  parameter int ACC_WIDTH = 64,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 CLK,
  input  logic                 SCLR_N,
  input  logic [P_WIDTH-1:0]   P,
  input  logic                 P_VALID,
  input  logic                 P_LAST,
  output logic                 P_READY,
  output logic [ACC_WIDTH-1:0] ACC,
  output logic                 ACC_VALID,
  input  logic                 ACC_READY,
  output logic                 OVF,
  output logic [15:0]          CNT
);
  state_e state_q, state_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d, acc_q, acc_d, add_a, add_sum, p_ext;
  logic [15:0] pcnt_q, pcnt_d, cnt_q, cnt_d, beat_cnt;
  logic povf_q, povf_d, ovf_q, ovf_d, acc_valid_q, acc_valid_d;
  logic idle, accept, add_ovf, beat_ovf;
  assign p_ext = ACC_WIDTH'($signed(P));
  assign idle = state_q == IDLE;
  assign add_a = idle ? '0 : sum_q;
  mistral_sat_add #(.W(ACC_WIDTH), .SAT(SATURATE)) u_add (
    .a(add_a), .b(p_ext), .sum(add_sum), .ovf(add_ovf)
  );
  assign P_READY = !(acc_valid_q && !ACC_READY);
  assign accept = P_VALID && P_READY;
  assign beat_cnt = idle ? 16'd1 : (pcnt_q == CNT_MAX ? pcnt_q : pcnt_q + 16'd1);
  assign beat_ovf = (!idle && povf_q) || add_ovf;
  always_comb begin
    state_d = state_q;
    sum_d = sum_q;
    pcnt_d = pcnt_q;
    povf_d = povf_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    acc_valid_d = (accept && P_LAST) ? 1'b1 : (acc_valid_q && ACC_READY) ? 1'b0 : acc_valid_q;
    if (accept && P_LAST) begin
      state_d = IDLE;
      acc_d = add_sum;
      cnt_d = beat_cnt;
      ovf_d = beat_ovf;
    end else if (accept) begin
      state_d = ACCUM;
      sum_d = add_sum;
      pcnt_d = beat_cnt;
      povf_d = beat_ovf;
    end
  end
  always_ff @(posedge CLK) begin
    if (!SCLR_N) begin
      state_q <= IDLE;
      sum_q <= '0;
      pcnt_q <= '0;
      povf_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q <= sum_d;
      pcnt_q <= pcnt_d;
      povf_q <= povf_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end
  assign ACC = acc_q;
  assign CNT = cnt_q;
  assign OVF = ovf_q;
  assign ACC_VALID = acc_valid_q;
endmodule

// File: tb/tb_mistral_mac_accum.sv
// tb_mistral_mac_accum: directed vectors, corner sequences and a random model check of the MAC accumulator.
module tb_mistral_mac_accum;
  logic clk = 1'b0, sclr_n = 1'b0;
  logic [53:0] p = '0;
  logic p_valid = 1'b0, p_last = 1'b0, acc_ready = 1'b0;
  logic pr_a, pr_s, pr_w, av_a, av_s, av_w, ovf_a, ovf_s, ovf_w;
  logic [63:0] acc_a;
  logic [53:0] acc_s, acc_w;
  logic [15:0] cnt_a, cnt_s, cnt_w;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  mistral_mac_accum u_a (
    .CLK(clk), .SCLR_N(sclr_n), .P(p), .P_VALID(p_valid), .P_LAST(p_last), .P_READY(pr_a),
    .ACC(acc_a), .ACC_VALID(av_a), .ACC_READY(acc_ready), .OVF(ovf_a), .CNT(cnt_a)
  );
  mistral_mac_accum #(.P_WIDTH(54), .ACC_WIDTH(54), .SATURATE(1'b1)) u_s (
    .CLK(clk), .SCLR_N(sclr_n), .P(p), .P_VALID(p_valid), .P_LAST(p_last), .P_READY(pr_s),
    .ACC(acc_s), .ACC_VALID(av_s), .ACC_READY(acc_ready), .OVF(ovf_s), .CNT(cnt_s)
  );
  mistral_mac_accum #(.P_WIDTH(54), .ACC_WIDTH(54), .SATURATE(1'b0)) u_w (
    .CLK(clk), .SCLR_N(sclr_n), .P(p), .P_VALID(p_valid), .P_LAST(p_last), .P_READY(pr_w),
    .ACC(acc_w), .ACC_VALID(av_w), .ACC_READY(acc_ready), .OVF(ovf_w), .CNT(cnt_w)
  );

  typedef struct {
    logic [53:0] p;
    logic v, l, ar, ev, eovf;
    logic [63:0] eacc;
    logic [15:0] ecnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic drive(input logic [53:0] pv, input logic v, input logic l, input logic ar);
    p = pv;
    p_valid = v;
    p_last = l;
    acc_ready = ar;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] m_sum, m_acc, r;
  logic [15:0] m_cnt, m_ocnt;
  logic m_ovf, m_oovf, m_idle, m_valid, m_pr, v, l, ar, fits, new_ovf;
  logic [127:0] ext, t;
  logic [15:0] new_cnt;
  int groups, cycles;

  initial begin
    tbl[0] = '{p: 54'(3),  v: 1, l: 0, ar: 1, ev: 0, eovf: 0, eacc: 64'(0),  ecnt: 16'd0};
    tbl[1] = '{p: 54'(-5), v: 1, l: 0, ar: 1, ev: 0, eovf: 0, eacc: 64'(0),  ecnt: 16'd0};
    tbl[2] = '{p: 54'(10), v: 1, l: 1, ar: 1, ev: 1, eovf: 0, eacc: 64'(8),  ecnt: 16'd3};
    tbl[3] = '{p: 54'(-7), v: 1, l: 1, ar: 1, ev: 1, eovf: 0, eacc: 64'(-7), ecnt: 16'd1};
    tbl[4] = '{p: 54'(0),  v: 0, l: 0, ar: 1, ev: 0, eovf: 0, eacc: 64'(-7), ecnt: 16'd1};

    drive(54'd0, 0, 0, 1);
    repeat (2) tick;
    chk("rst_valid", av_a, 0);
    chk("rst_acc", acc_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_pready", {pr_a, pr_s, pr_w}, 3'b111);
    sclr_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].p, tbl[i].v, tbl[i].l, tbl[i].ar);
      tick;
      chk($sformatf("tbl%0d_valid", i), av_a, tbl[i].ev);
      chk($sformatf("tbl%0d_acc", i), acc_a, tbl[i].eacc);
      chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].ecnt);
      chk($sformatf("tbl%0d_ovf", i), ovf_a, tbl[i].eovf);
    end

    drive(54'd1, 1, 0, 1);
    tick;
    drive(54'd5, 1, 1, 0);
    tick;
    chk("stall_first_acc", acc_a, 6);
    chk("stall_first_cnt", cnt_a, 2);
    for (int i = 0; i < 5; i++) begin
      drive(54'd100, 1, 0, 0);
      tick;
      chk($sformatf("stall%0d_pready", i), pr_a, 0);
      chk($sformatf("stall%0d_valid", i), av_a, 1);
      chk($sformatf("stall%0d_acc", i), acc_a, 6);
    end
    drive(54'd9, 1, 1, 1);
    #1;
    chk("release_pready", pr_a, 1);
    tick;
    chk("release_valid", av_a, 1);
    chk("release_acc", acc_a, 9);
    chk("release_cnt", cnt_a, 1);
    drive(54'd0, 0, 0, 1);
    tick;
    chk("drain_valid", av_a, 0);

    drive(54'h10_0000_0000_0000, 1, 0, 1);
    tick;
    drive(54'h10_0000_0000_0000, 1, 1, 1);
    tick;
    chk("sat_acc", acc_s, 54'h1F_FFFF_FFFF_FFFF);
    chk("sat_ovf", {av_s, ovf_s}, 2'b11);
    chk("sat_cnt", cnt_s, 2);
    chk("wrap_acc", acc_w, 54'h20_0000_0000_0000);
    chk("wrap_ovf", {av_w, ovf_w}, 2'b11);
    chk("wrap_cnt", cnt_w, 2);
    chk("wide_acc", acc_a, 64'h20_0000_0000_0000);
    chk("wide_ovf", ovf_a, 0);
    drive(54'd0, 0, 0, 1);
    tick;

    drive(54'd7, 1, 0, 1);
    tick;
    drive(54'd8, 1, 0, 1);
    tick;
    sclr_n = 1'b0;
    drive(54'd99, 1, 1, 1);
    tick;
    chk("midrst_valid", av_a, 0);
    chk("midrst_acc", acc_a, 0);
    chk("midrst_cnt", cnt_a, 0);
    sclr_n = 1'b1;
    drive(54'd4, 1, 1, 1);
    tick;
    chk("postrst_acc", acc_a, 4);
    chk("postrst_cnt", cnt_a, 1);
    chk("postrst_valid", av_a, 1);

    sclr_n = 1'b0;
    drive(54'd0, 0, 0, 1);
    tick;
    sclr_n = 1'b1;
    m_sum = '0; m_acc = '0; m_cnt = '0; m_ocnt = '0;
    m_ovf = 0; m_oovf = 0; m_idle = 1; m_valid = 0;
    groups = 0;
    cycles = 0;
    while (groups < 10000 && cycles < 60000) begin
      v = $urandom_range(7) != 0;
      ar = $urandom_range(7) != 0;
      l = $urandom_range(1) == 0;
      if ($urandom_range(3) == 0) begin
        r = {$urandom, $urandom};
        p = r[53:0];
      end else p = 54'(int'($urandom_range(200)) - 100);
      drive(p, v, l, ar);
      m_pr = !(m_valid && !ar);
      #1;
      chk("rnd_pready", pr_a, m_pr);
      if (v && m_pr) begin
        ext = {{74{p[53]}}, p};
        t = m_idle ? ext : {{64{m_sum[63]}}, m_sum} + ext;
        fits = (t[127:63] == '0) || (t[127:63] == '1);
        new_ovf = (!m_idle && m_ovf) || !fits;
        new_cnt = m_idle ? 16'd1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
        if (l) begin
          m_acc = t[63:0]; m_ocnt = new_cnt; m_oovf = new_ovf;
          m_valid = 1; m_idle = 1;
          groups++;
        end else begin
          m_sum = t[63:0]; m_cnt = new_cnt; m_ovf = new_ovf; m_idle = 0;
          if (m_valid && ar) m_valid = 0;
        end
      end else if (m_valid && ar) m_valid = 0;
      tick;
      cycles++;
      chk("rnd_valid", av_a, m_valid);
      chk("rnd_acc", acc_a, m_acc);
      chk("rnd_cnt", cnt_a, m_ocnt);
      chk("rnd_ovf", ovf_a, m_oovf);
    end
    chk("rnd_groups_done", groups, 10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mistral_mac_accum.md
MISTRAL_MAC_ACCUM -- requirements
Module: mistral_mac_accum

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 54: width of the signed product input.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 64: width of the accumulator and result; legal range P_WIDTH..96.
REQ-003 The block SHALL have parameter SATURATE, default 0: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 The block SHALL have port CLK, input, 1: sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port SCLR_N, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port P, input, P_WIDTH: signed product from the upstream multiplier output Y.
REQ-007 The block SHALL have port P_VALID, input, 1: P and P_LAST valid.
REQ-008 The block SHALL have port P_LAST, input, 1: the beat is the final product of a group.
REQ-009 The block SHALL have port P_READY, output, 1: block accepts a beat this cycle.
REQ-010 The block SHALL have port ACC, output, ACC_WIDTH: signed group sum.
REQ-011 The block SHALL have port ACC_VALID, output, 1: ACC holds an unconsumed result.
REQ-012 The block SHALL have port ACC_READY, input, 1: downstream consumes ACC this cycle.
REQ-013 The block SHALL have port OVF, output, 1: an overflow occurred in the group that produced ACC.
REQ-014 The block SHALL have port CNT, output, 16: number of beats in the group that produced ACC; saturates at 65535.

Function
REQ-015 Beat accepted SHALL mean P_VALID && P_READY; output consumed SHALL mean ACC_VALID && ACC_READY.
REQ-016 P_READY SHALL be the combinational value !(ACC_VALID && !ACC_READY); it SHALL have no dependency on P_VALID.
REQ-017 Partial-sum FSM: states IDLE (no partial sum) and ACCUM (partial sum held); reset state IDLE.
REQ-018 IDLE with an accepted beat and !P_LAST: sum <= sext(P), beat count <= 1, overflow <= 0, state -> ACCUM.
REQ-019 ACCUM with an accepted beat and !P_LAST: sum <= sum + sext(P), beat count incremented (saturating), overflow sticky-ORed, state remains ACCUM.
REQ-020 On an accepted P_LAST beat, the final sum (REQ-018/019 arithmetic applied to the beat) SHALL load ACC, CNT and OVF, and ACC_VALID SHALL be set; state -> IDLE; latency is one cycle from acceptance to ACC_VALID.
REQ-021 A single-beat group (P_LAST in IDLE) SHALL produce ACC = sext(P), CNT = 1, OVF = 0.
REQ-022 Overflow SHALL be detected as signed overflow of the ACC_WIDTH addition; with SATURATE=1 the sum clamps to the max/min signed value and remains clamped until further beats move it back into range.
REQ-023 A consume without a new P_LAST SHALL clear ACC_VALID next cycle; ACC, CNT and OVF SHALL hold their values.
REQ-024 Simultaneous consume and accepted P_LAST SHALL reload the output with the new result, with ACC_VALID remaining 1 and no bubble.
REQ-025 While ACC_VALID && !ACC_READY, the output registers SHALL hold stable and no beat is accepted; the partial sum SHALL be preserved.
REQ-026 Beats with P_VALID=0 SHALL leave all state unchanged.

Reset
REQ-027 While SCLR_N=0 at a clock edge: state <= IDLE, ACC_VALID <= 0, ACC <= 0, CNT <= 0, OVF <= 0, and the partial sum SHALL be discarded.
REQ-028 During reset, P_READY SHALL follow REQ-016 from the register values; beats presented in the reset cycle SHALL be dropped.

Structure
REQ-029 The FSM state enum and saturation constants (ACC max/min, CNT max) SHALL live in shared package mistral_dsp_pkg.
REQ-030 The overflow-detecting, optionally saturating adder SHALL be the single sub-module mistral_sat_add.
REQ-031 No combinational path SHALL exist from P, P_VALID or P_LAST to any output.

Verification
REQ-032 The bench SHALL cover: beats P = 3, -5, 10 (last) -> one cycle later ACC=8, CNT=3, OVF=0, ACC_VALID=1.
REQ-033 The bench SHALL cover: single beat P=-7 with P_LAST -> ACC=-7, CNT=1.
REQ-034 The bench SHALL cover: ACC_READY=0 held for 5 cycles after a result -> P_READY=0, ACC stable; then ACC_READY=1 with a P_LAST beat in the same cycle -> new result next cycle and ACC_VALID never drops.
REQ-035 The bench SHALL cover: ACC_WIDTH=54, SATURATE=1, two beats of P=2^52 -> ACC=2^53-1, OVF=1; with SATURATE=0 -> ACC=-2^53, OVF=1.
REQ-036 The bench SHALL cover: SCLR_N pulsed low after 2 beats of a group, then beat P=4 (last) -> ACC=4, CNT=1.
REQ-037 The bench SHALL cover: random P_VALID/ACC_READY traffic against a reference model -> zero mismatches over 10,000 groups.
